// File: rtl/rv32_enc_pkg.sv
// =============================================================================
// rv32_enc_pkg : RV32I opcodes, op classes and immediate limits shared by the
//                program encoder and the core's opcode decoder.
// Rev 1.0
// =============================================================================
`default_nettype none

package rv32_enc_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,
        CLS_STORE  = 3'd1,
        CLS_RTYPE  = 3'd2,
        CLS_ITYPE  = 3'd3,
        CLS_BRANCH = 3'd4
    } op_class_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
    localparam logic signed [31:0] IMM13_MAX = 32'sd4094;

    function automatic logic imm_in_range(input logic signed [31:0] v,
                                          input logic signed [31:0] lo,
                                          input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_instr_pack.sv
// =============================================================================
// rv32_instr_pack : combinational packer, decoded descriptor -> RV32I word.
//                   Illegal descriptors yield NOP_WORD with illegal_o set.
// Rev 1.0
// =============================================================================
`default_nettype none

module rv32_instr_pack
    import rv32_enc_pkg::*;
(
    input  logic [2:0]  op_class_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7_5_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic signed [31:0] w_imm_s;
    logic               w_imm12_ok;
    logic               w_imm13_ok;
    logic [31:0]        w_word_raw;
    logic               w_illegal;

    assign w_imm_s    = imm_i;
    assign w_imm12_ok = imm_in_range(w_imm_s, IMM12_MIN, IMM12_MAX);
    // Branch offsets are halfword multiples; bit 0 is not encodable.
    assign w_imm13_ok = imm_in_range(w_imm_s, IMM13_MIN, IMM13_MAX) && !imm_i[0];

    always_comb begin
        w_word_raw = NOP_WORD;
        w_illegal  = 1'b0;
        case (op_class_e'(op_class_i))
            CLS_LOAD: begin
                w_word_raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
                w_illegal  = !w_imm12_ok;
            end
            CLS_ITYPE: begin
                w_word_raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_ITYPE};
                w_illegal  = !w_imm12_ok;
            end
            CLS_STORE: begin
                w_word_raw = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
                w_illegal  = !w_imm12_ok;
            end
            CLS_RTYPE: begin
                w_word_raw = {1'b0, funct7_5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OP_RTYPE};
            end
            CLS_BRANCH: begin
                w_word_raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                              imm_i[4:1], imm_i[11], OP_BRANCH};
                w_illegal  = !w_imm13_ok;
            end
            default: begin
                w_illegal  = 1'b1;
            end
        endcase
    end

    assign word_o    = w_illegal ? NOP_WORD : w_word_raw;
    assign illegal_o = w_illegal;

endmodule

`default_nettype wire

// File: rtl/imem_program_encoder.sv
// =============================================================================
// imem_program_encoder : accepts instruction descriptors, encodes them and
//                        writes them to consecutive instruction-memory words.
// Rev 1.0
// =============================================================================
`default_nettype none

module imem_program_encoder
    import rv32_enc_pkg::*;
#(
    parameter int AW   = 8,
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW:0]     num_words,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op_class,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [31:0]     imm,
    output logic            imem_we,
    output logic [AW-1:0]   imem_addr,
    output logic [31:0]     imem_wdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [ERRW-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [ERRW-1:0] ERR_MAX = '1;
    localparam logic [AW:0]     REM_ONE = (AW+1)'(1);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_ptr_q, addr_ptr_d;
    logic [AW:0]     remaining_q, remaining_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;
    logic            done_q, done_d;

    logic            w_accept;
    logic [31:0]     w_enc_word;
    logic            w_enc_illegal;

    rv32_instr_pack u_pack (
        .op_class_i (op_class),
        .rd_i       (rd),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .funct3_i   (funct3),
        .funct7_5_i (funct7_5),
        .imm_i      (imm),
        .word_o     (w_enc_word),
        .illegal_o  (w_enc_illegal)
    );

    // Ready depends only on registered state so upstream can't form a loop.
    assign in_ready = (state_q == S_LOAD) && (remaining_q != '0);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        addr_ptr_d  = addr_ptr_q;
        remaining_d = remaining_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d       = 1'b0;
                    err_cnt_d   = '0;
                    addr_ptr_d  = base_addr;
                    remaining_d = num_words;
                    state_d     = (num_words == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    we_d        = 1'b1;
                    waddr_d     = addr_ptr_q;
                    wdata_d     = w_enc_word;
                    addr_ptr_d  = addr_ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (w_enc_illegal) begin
                        err_d = 1'b1;
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    if (remaining_q == REM_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_ptr_q  <= '0;
            remaining_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_ptr_q  <= addr_ptr_d;
            remaining_q <= remaining_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            done_q      <= done_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign done       = done_q;
    assign err        = err_q;
    assign err_count  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_program_encoder.sv
// =============================================================================
// tb_imem_program_encoder : directed descriptors with hand-encoded words; a
//                           scoreboard queue is checked by a write monitor.
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_imem_program_encoder;

    localparam int AW   = 8;
    localparam int ERRW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [AW:0]     num_words = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op_class = '0;
    logic [4:0]      rd = '0;
    logic [4:0]      rs1 = '0;
    logic [4:0]      rs2 = '0;
    logic [2:0]      funct3 = '0;
    logic            funct7_5 = 1'b0;
    logic [31:0]     imm = '0;
    logic            imem_we;
    logic [AW-1:0]   imem_addr;
    logic [31:0]     imem_wdata;
    logic            busy;
    logic            done;
    logic            err;
    logic [ERRW-1:0] err_count;

    imem_program_encoder #(.AW(AW), .ERRW(ERRW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_class   (op_class),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .imm        (imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   word;
        int            acc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [AW-1:0] exp_addr = '0;
    int            last_acc = 0;
    int            start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Write monitor: each write must match the oldest expectation and land
    // exactly one cycle after its accept.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].acc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_write: no write seen, expected addr %h data %h", sb[0].addr, sb[0].word);
                void'(sb.pop_front());
            end
            if (imem_we) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_addr, imem_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.word || cyc != mon_e.acc) begin
                        n_fail++;
                        $display("FAIL write: got addr %h data %h cycle %0d, expected addr %h data %h cycle %0d",
                                 imem_addr, imem_wdata, cyc, mon_e.addr, mon_e.word, mon_e.acc);
                    end
                end
            end
        end
    end

    task automatic start_session(input logic [AW-1:0] b, input logic [AW:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        exp_addr  = b;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic send(input logic [2:0] oc, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                        input logic [31:0] im, input logic [31:0] exp_word);
        in_valid = 1'b1;
        op_class = oc;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        funct3   = f3;
        funct7_5 = f7;
        imm      = im;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{addr: exp_addr, word: exp_word, acc: cyc + 1});
                last_acc = cyc + 1;
                exp_addr = exp_addr + 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready got 0 for 20 cycles, expected 1");
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done) begin
                check("done_cycle", cyc, exp_cyc);
                @(negedge clk);
                check("done_one_cycle", {31'b0, done}, 32'd0);
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL done_timeout: done got 0 for 20 cycles, expected 1");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we",       {31'b0, imem_we}, 32'd0);
        check("rst_addr",     {24'b0, imem_addr}, 32'd0);
        check("rst_wdata",    imem_wdata, 32'd0);
        check("rst_busy",     {31'b0, busy}, 32'd0);
        check("rst_done",     {31'b0, done}, 32'd0);
        check("rst_err",      {31'b0, err}, 32'd0);
        check("rst_errcnt",   {24'b0, err_count}, 32'd0);
        check("rst_ready",    {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Mixed classes, back-to-back
        start_session(8'h10, 9'd4);
        check("a_busy", {31'b0, busy}, 32'd1);
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 32'd8,  32'h0081_2283);
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0,  32'h4020_81B3);
        send(3'd1, 5'd0, 5'd7, 5'd6, 3'd2, 1'b0, -32'sd4, 32'hFE63_AE23);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8,  32'h0020_8463);
        wait_done(last_acc + 1);
        check("a_err",    {31'b0, err}, 32'd0);
        check("a_errcnt", {24'b0, err_count}, 32'd0);

        // in_valid 1,0,0,1 with I-immediate range edges
        start_session(8'h20, 9'd2);
        send(3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, -32'sd2048, 32'h8000_0093);
        @(negedge clk);
        check("b_stall_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        send(3'd3, 5'd2, 5'd3, 5'd0, 3'd7, 1'b0, 32'd2047, 32'h7FF1_F113);
        @(negedge clk);
        check("b_ready_drop", {31'b0, in_ready}, 32'd0);
        check("b_drain_busy", {31'b0, busy}, 32'd1);
        wait_done(last_acc + 1);
        check("b_err", {31'b0, err}, 32'd0);

        // Illegal descriptors become NOPs and are counted
        start_session(8'h30, 9'd3);
        send(3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 32'h0000_0013);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd7,    32'h0000_0013);
        send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0,    32'h0000_0013);
        wait_done(last_acc + 1);
        check("c_err",    {31'b0, err}, 32'd1);
        check("c_errcnt", {24'b0, err_count}, 32'd3);

        // Address wrap; start during LOAD must not re-base
        start_session(8'hFF, 9'd2);
        check("d_err_clr",    {31'b0, err}, 32'd0);
        check("d_errcnt_clr", {24'b0, err_count}, 32'd0);
        send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 32'h0000_0083);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 8'h80;
        num_words = 9'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        send(3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 32'h0000_0023);
        wait_done(last_acc + 1);

        // Empty session
        start_session(8'h50, 9'd0);
        @(negedge clk);
        check("e_done",      {31'b0, done}, 32'd1);
        check("e_done_cyc",  cyc, start_cyc);
        check("e_ready0",    {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("e_done_low",  {31'b0, done}, 32'd0);
        check("e_ready1",    {31'b0, in_ready}, 32'd0);
        check("e_busy",      {31'b0, busy}, 32'd0);

        // Reset mid-LOAD with a write in flight
        start_session(8'h40, 9'd3);
        send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 32'h0000_0013);
        check("f_err_pre", {31'b0, err}, 32'd1);
        in_valid = 1'b1;
        op_class = 3'd0;
        rd       = 5'd9;
        rs1      = 5'd4;
        funct3   = 3'd2;
        imm      = 32'd16;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("f_we",     {31'b0, imem_we}, 32'd0);
        check("f_busy",   {31'b0, busy}, 32'd0);
        check("f_done",   {31'b0, done}, 32'd0);
        check("f_err",    {31'b0, err}, 32'd0);
        check("f_errcnt", {24'b0, err_count}, 32'd0);
        check("f_ready",  {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("f_ready_idle", {31'b0, in_ready}, 32'd0);
            check("f_we_idle",    {31'b0, imem_we}, 32'd0);
        end

        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_program_encoder.md
Name: imem_program_encoder

Overview:
- Encoder counterpart to the processor's main opcode decoder: accepts decoded-form instruction descriptors (op class, register indices, funct fields, signed immediate), packs them into RV32I machine words, and writes them sequentially into instruction memory.
- Used as the program loader / self-test stimulus source ahead of the single-cycle core.
- Covers exactly the classes the core decodes: LOAD, STORE, R-type ALU, I-type ALU, BRANCH.

Parameters:
- AW, 8, instruction-memory word-address width.
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a load session. Honoured only in IDLE.
- base_addr  in  AW  first word address; sampled on start.
- num_words  in  AW+1  descriptors to accept; sampled on start.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid & in_ready.
- op_class  in  3  0=LOAD, 1=STORE, 2=RTYPE, 3=ITYPE, 4=BRANCH, 5-7 illegal.
- rd, rs1, rs2  in  5 each  register indices. Unused fields are ignored.
- funct3  in  3  funct3 field.
- funct7_5  in  1  instr[30] for RTYPE. Ignored otherwise.
- imm  in  32  signed immediate, two's complement.
- imem_we  out  1  registered write strobe.
- imem_addr  out  AW  registered word address.
- imem_wdata  out  32  registered encoded word.
- busy  out  1  high in LOAD and DRAIN.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky; at least one descriptor was illegal in this session.
- err_count  out  ERRW  saturating count of illegal descriptors.

Behaviour:
- Reset: state IDLE. All outputs 0, including imem_addr, imem_wdata, err and err_count. Any pending write is dropped; no write occurs after rst rises.
- FSM: IDLE, LOAD, DRAIN, DONE.
- IDLE -> LOAD on start with num_words != 0. The start cycle also clears err and err_count, loads addr_ptr=base_addr and remaining=num_words.
- IDLE -> DONE on start with num_words == 0. No writes.
- start outside IDLE is ignored.
- LOAD: in_ready = (remaining != 0), combinational from registered state only; it does not depend on in_valid.
- On accept: remaining decrements and addr_ptr increments modulo 2^AW (wrap from 2^AW-1 to 0 is legal).
- Accepting the final descriptor moves the FSM to DRAIN; in_ready is 0 from the next cycle.
- in_valid low stalls indefinitely with no writes.
- DRAIN: final write is presented; next state DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency: descriptor accepted at edge N -> imem_we=1 for exactly the cycle after edge N, carrying imem_addr/imem_wdata. Back-to-back accepts give back-to-back writes at consecutive addresses. done rises 2 cycles after the final accept.
- Encoding, RV32I standard:
  - LOAD opcode 0000011, I-format.
  - ITYPE opcode 0010011, I-format.
  - STORE opcode 0100011, S-format.
  - RTYPE opcode 0110011, funct7={1'b0,funct7_5,5'b0}.
  - BRANCH opcode 1100011, B-format with imm[12|10:5] and imm[4:1|11].
- Legality:
  - I and S formats require -2048 <= imm <= 2047.
  - B format requires -4096 <= imm <= 4094 with imm[0]=0.
  - op_class 5-7 is illegal.
- Illegal descriptor: still consumes a slot and an address. The word written is NOP 0x00000013, err is set, and err_count increments, saturating at 2^ERRW-1.
- Reset mid-session returns the block to IDLE. Memory contents already written are not the block's concern.

Decomposition:
- Shared package rv32_enc_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH), also usable by the decoder;
  - op_class enum;
  - NOP_WORD constant;
  - immediate range constants.
- One combinational sub-module, rv32_instr_pack: descriptor in -> {word, illegal} out. The top holds the FSM, counters and output registers.

Test Plan:
- Reset mid-LOAD with a write pending -> next cycle imem_we=0, busy=0, done=0, err=0, err_count=0; in_ready=0 until the next start.
- start base=0x10 num=4; descriptors:
  - LOAD rd=5 rs1=2 f3=2 imm=8 -> 0x00812283 @0x10
  - RTYPE rd=3 rs1=1 rs2=2 f3=0 f7_5=1 -> 0x402081B3 @0x11
  - STORE rs1=7 rs2=6 f3=2 imm=-4 -> 0xFE63AE23 @0x12
  - BRANCH rs1=1 rs2=2 f3=0 imm=8 -> 0x00208463 @0x13
  - After the last write: done pulse 2 cycles after the final accept; err=0.
- in_valid toggled 1,0,0,1 with num=2 -> exactly 2 writes, each 1 cycle after its accept; in_ready drops after the 2nd accept.
- ITYPE imm=2048, then BRANCH imm=7, then op_class=6, num=3 -> three writes of 0x00000013; err=1; err_count=3.
- base=0xFF (AW=8) num=2 -> writes at 0xFF then 0x00; start pulsed during LOAD is ignored (no re-base).
- start num=0 -> no imem_we; done one cycle later; in_ready never asserted.
